// File: rtl/half_duplex_pin_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// half_duplex_pin_ctrl_pkg
//   Shared definitions for the half-duplex pin sequencer: FSM state encodings,
//   the level the pin idles at, and the pad_oe polarity.
//   No ports; imported by half_duplex_pin_ctrl.
// -----------------------------------------------------------------------------
package half_duplex_pin_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_TURN = 3'd2,
        ST_RX   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Level presented on pad_out whenever no data bit is being sent.
    localparam logic IDLE_LEVEL = 1'b1;

    // pad_oe polarity: 1 means this block drives the pin.
    localparam logic OE_DRIVE   = 1'b1;
    localparam logic OE_RELEASE = 1'b0;

endpackage

// File: rtl/hdpc_bit_timer.sv
// -----------------------------------------------------------------------------
// hdpc_bit_timer
//   Free-running BIT_DIV divider shared by the TX and RX phases.
//   Ports:
//     clk    in   system clock
//     rst    in   synchronous active-high reset
//     clear  in   hold the count at window cycle 0
//     tick   out  last cycle of the current bit window
//     mid    out  sample cycle of the window (cycle floor(BIT_DIV/2))
// -----------------------------------------------------------------------------
module hdpc_bit_timer #(
    parameter int BIT_DIV = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic mid
);

    localparam int                CNT_W    = $clog2(BIT_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BIT_DIV / 2);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);
    assign mid  = (cnt == CNT_MID);

endmodule

// File: rtl/half_duplex_pin_ctrl.sv
// -----------------------------------------------------------------------------
// half_duplex_pin_ctrl
//   Sequencer in front of a tristate pad buffer. Shifts a word out MSB first,
//   optionally releases the pin for a turnaround gap, then samples a reply
//   word MSB first from the same pin.
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous active-high reset
//     start    in   request pulse, honoured only while idle
//     tx_data  in   word to send, captured with start
//     rx_en    in   expect a reply, captured with start
//     busy     out  transaction in progress (TX, TURN, RX, DONE)
//     done     out  one-cycle completion pulse
//     rx_data  out  last received word
//     pad_out  out  pad buffer data input
//     pad_oe   out  pad buffer direction, 1 = drive the pin
//     pad_in   in   pin value from the pad buffer
// -----------------------------------------------------------------------------
module half_duplex_pin_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int BIT_DIV     = 12,
    parameter int TURN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  rx_en,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  pad_out,
    output logic                  pad_oe,
    input  logic                  pad_in
);

    import half_duplex_pin_ctrl_pkg::*;

    localparam int                BIT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    // A single turnaround cycle still needs a 1-bit counter.
    localparam int                TURN_W    = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

    state_t                  state;
    logic [BIT_W-1:0]        bit_cnt;
    logic [TURN_W-1:0]       turn_cnt;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic                    rx_en_q;

    logic [DATA_WIDTH-1:0]   tx_next;
    logic [DATA_WIDTH-1:0]   rx_next;
    logic                    timer_clear;
    logic                    tick;
    logic                    mid;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tx_next     = tx_shift << 1;
        rx_next     = rx_shift << 1;
        rx_next[0]  = pad_in;
        // The divider only runs in the bit-timed phases; holding it cleared
        // elsewhere means TX and RX both start at window cycle 0.
        timer_clear = 1'b1;
        if (state == ST_TX || state == ST_RX) begin
            timer_clear = 1'b0;
        end
    end

    hdpc_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick),
        .mid   (mid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            turn_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_en_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            pad_oe   <= OE_RELEASE;
            pad_out  <= IDLE_LEVEL;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy     <= 1'b0;
                    pad_oe   <= OE_RELEASE;
                    pad_out  <= IDLE_LEVEL;
                    bit_cnt  <= '0;
                    turn_cnt <= '0;
                    if (start) begin
                        tx_shift <= tx_data;
                        rx_shift <= '0;
                        rx_en_q  <= rx_en;
                        busy     <= 1'b1;
                        // First bit goes out together with taking the pin.
                        pad_oe   <= OE_DRIVE;
                        pad_out  <= tx_data[DATA_WIDTH-1];
                        state    <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            pad_oe  <= OE_RELEASE;
                            pad_out <= IDLE_LEVEL;
                            if (rx_en_q) begin
                                state <= ST_TURN;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tx_shift <= tx_next;
                            pad_out  <= tx_next[DATA_WIDTH-1];
                        end
                    end
                end

                ST_TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        turn_cnt <= '0;
                        state    <= ST_RX;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end

                ST_RX: begin
                    if (mid) begin
                        rx_shift <= rx_next;
                    end
                    if (tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                            // With BIT_DIV=2 the last sample and the last tick
                            // coincide, so publish the post-sample word.
                            if (rx_en_q) begin
                                rx_data <= mid ? rx_next : rx_shift;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_duplex_pin_ctrl.sv
// -----------------------------------------------------------------------------
// tb_half_duplex_pin_ctrl
//   Self-checking bench for half_duplex_pin_ctrl with DATA_WIDTH=8, BIT_DIV=4,
//   TURN_CYCLES=2. Each transaction pushes its expected completion (cycle and
//   rx_data) to a scoreboard; a monitor pops it on every done pulse. Pin
//   direction and level are compared against a cycle model as the
//   transaction runs, and the bench plays the far side during RX.
// -----------------------------------------------------------------------------
module tb_half_duplex_pin_ctrl;

    localparam int W = 8;
    localparam int D = 4;
    localparam int T = 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] tx_data;
    logic         rx_en;
    logic         busy;
    logic         done;
    logic [W-1:0] rx_data;
    logic         pad_out;
    logic         pad_oe;
    logic         pad_in;

    typedef struct packed {
        logic [W-1:0] rx;
        logic [31:0]  cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    logic [W-1:0] model_rx = '0;

    half_duplex_pin_ctrl #(
        .DATA_WIDTH  (W),
        .BIT_DIV     (D),
        .TURN_CYCLES (T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .rx_en   (rx_en),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .pad_out (pad_out),
        .pad_oe  (pad_oe),
        .pad_in  (pad_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest pending entry.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), e.cyc);
                check("rx_data", 32'(rx_data), 32'(e.rx));
            end
        end
    end

    // One transaction driven from the negedge before acceptance. pulse_a/b
    // re-assert start in those cycles (0 = none); abort_at asserts rst in that
    // cycle and checks the released pin in the next one (0 = run to done).
    task automatic do_txn(input logic [W-1:0] data, input logic rxen,
                          input logic [W-1:0] reply, input bit glitch,
                          input int pulse_a, input int pulse_b, input int abort_at);
        int   lat;
        int   rx0;
        int   c0;
        logic e_oe;
        logic e_out;
        lat = rxen ? (2 * W * D + T + 1) : (W * D + 1);
        rx0 = W * D + T + 1;
        @(negedge clk);
        c0      = cyc;
        start   = 1'b1;
        tx_data = data;
        rx_en   = rxen;
        if (rxen) model_rx = reply;
        if (abort_at == 0) sb.push_back('{rx: model_rx, cyc: 32'(c0 + lat)});
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (abort_at != 0 && k == abort_at + 1) begin
                rst = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_pad_oe", 32'(pad_oe), 32'd0);
                check("abort_pad_out", 32'(pad_out), 32'd1);
                check("abort_done", 32'(done), 32'd0);
                check("abort_rx_data", 32'(rx_data), 32'd0);
                model_rx = '0;
                return;
            end
            if (k <= W * D) begin
                e_oe  = 1'b1;
                e_out = data[W - 1 - (k - 1) / D];
            end else begin
                e_oe  = 1'b0;
                e_out = 1'b1;
            end
            check($sformatf("k%0d_pad_oe", k), 32'(pad_oe), 32'(e_oe));
            check($sformatf("k%0d_pad_out", k), 32'(pad_out), 32'(e_out));
            check($sformatf("k%0d_busy", k), 32'(busy), 32'd1);
            start = (k == pulse_a || k == pulse_b) ? 1'b1 : 1'b0;
            if (rxen && k >= rx0 && k < rx0 + W * D) begin
                pad_in = reply[W - 1 - (k - rx0) / D] ^ (glitch && ((k - rx0) % D != D / 2));
            end else begin
                pad_in = 1'b0;
            end
            if (k == abort_at) rst = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_pad_oe", 32'(pad_oe), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        tx_data = '0;
        rx_en   = 1'b0;
        pad_in  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_pad_oe", 32'(pad_oe), 32'd0);
        check("rst_pad_out", 32'(pad_out), 32'd1);
        rst = 1'b0;
        idle_cycles(2);

        // TX only; rx_data must stay at its reset value.
        do_txn(8'hA5, 1'b0, 8'h00, 1'b0, 0, 0, 0);
        idle_cycles(3);
        // TX then reply 0xC3 from the far side.
        do_txn(8'h3C, 1'b1, 8'hC3, 1'b0, 0, 0, 0);
        idle_cycles(3);
        // Start pulses while busy are ignored.
        do_txn(8'hA5, 1'b0, 8'h00, 1'b0, 5, 20, 0);
        idle_cycles(3);
        // Reset mid-RX-transaction.
        do_txn(8'h5A, 1'b1, 8'h77, 1'b0, 0, 0, 40);
        idle_cycles(3);
        // Back-to-back: second start in the cycle right after done.
        do_txn(8'hFF, 1'b0, 8'h00, 1'b0, 0, 0, 0);
        do_txn(8'h00, 1'b0, 8'h00, 1'b0, 0, 0, 0);
        idle_cycles(3);
        // Reply with glitches everywhere except the sample cycle.
        do_txn(8'h5A, 1'b1, 8'h81, 1'b1, 0, 0, 0);
        idle_cycles(4);
        check("final_rx_data", 32'(rx_data), 32'h81);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
